s2p_rx: RTL

- Serial-to-parallel receiver; receive-side counterpart of the team's parallel-to-serial transmitter.
- Frame format: one bit per clk while framing strobe frame_n is low, MSB first, exactly WIDTH bits per frame, frames separated by ≥1 cycle of frame_n high.
- Assembles each frame into a word and presents it on a valid/ready output port; flags framing errors and overruns.
- Sits on the MISO/loopback side of the serial link, feeding a register file or FIFO.

---
 rtl/s2p_rx.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/s2p_rx.sv
// ============================================================================
// s2p_rx : serial-to-parallel receiver with valid/ready output and error flags
// Optional: define S2P_RX_SYNC_EN to add 2-flop input synchronizers.
// Revision: 1.0
// ============================================================================
`default_nettype none

module s2p_rx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             s_in,
    input  logic             frame_n,
    output logic [WIDTH-1:0] d_out,
    output logic             valid,
    input  logic             ready,
    output logic             overrun,
    output logic             framing_err,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2
    } state_t;

    logic s_bit;
    logic frm_n;

`ifdef S2P_RX_SYNC_EN
    logic [1:0] s_sync;
    logic [1:0] f_sync;

    // Idle values (data low, strobe high) so reset never looks like a frame start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_sync <= 2'b00;
            f_sync <= 2'b11;
        end else begin
            s_sync <= {s_sync[0], s_in};
            f_sync <= {f_sync[0], frame_n};
        end
    end

    assign s_bit = s_sync[1];
    assign frm_n = f_sync[1];
`else
    assign s_bit = s_in;
    assign frm_n = frame_n;
`endif

    state_t           state;
    state_t           state_nxt;
    // Only WIDTH-1 bits are kept: the final bit is taken straight from s_bit.
    logic [WIDTH-2:0] shift;
    logic [WIDTH-2:0] shift_nxt;
    logic [CW-1:0]    bit_cnt;
    logic [CW-1:0]    bit_cnt_nxt;
    logic             extra;
    logic             extra_nxt;
    logic [WIDTH-1:0] word;
    logic             word_done;
    logic [WIDTH-1:0] d_out_nxt;
    logic             valid_nxt;
    logic             overrun_nxt;
    logic             framing_err_nxt;
    logic             busy_nxt;

    assign word = {shift, s_bit};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            shift       <= '0;
            bit_cnt     <= '0;
            extra       <= 1'b0;
            d_out       <= '0;
            valid       <= 1'b0;
            overrun     <= 1'b0;
            framing_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            shift       <= shift_nxt;
            bit_cnt     <= bit_cnt_nxt;
            extra       <= extra_nxt;
            d_out       <= d_out_nxt;
            valid       <= valid_nxt;
            overrun     <= overrun_nxt;
            framing_err <= framing_err_nxt;
            busy        <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        shift_nxt       = shift;
        bit_cnt_nxt     = bit_cnt;
        extra_nxt       = extra;
        word_done       = 1'b0;
        framing_err_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (!frm_n) begin
                    shift_nxt   = word[WIDTH-2:0];
                    bit_cnt_nxt = CW'(1);
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                if (!frm_n) begin
                    shift_nxt = word[WIDTH-2:0];
                    if (bit_cnt == CW'(WIDTH - 1)) begin
                        word_done   = 1'b1;
                        bit_cnt_nxt = '0;
                        state_nxt   = DRAIN;
                    end else begin
                        bit_cnt_nxt = bit_cnt + CW'(1);
                    end
                end else begin
                    framing_err_nxt = 1'b1;
                    bit_cnt_nxt     = '0;
                    state_nxt       = IDLE;
                end
            end
            DRAIN: begin
                if (!frm_n) begin
                    extra_nxt = 1'b1;
                end else begin
                    framing_err_nxt = extra;
                    extra_nxt       = 1'b0;
                    state_nxt       = IDLE;
                end
            end
            default: begin
                state_nxt   = IDLE;
                bit_cnt_nxt = '0;
                extra_nxt   = 1'b0;
            end
        endcase
    end

    // Output holding register: a completing word may replace one being consumed this cycle.
    always_comb begin
        d_out_nxt   = d_out;
        valid_nxt   = valid;
        overrun_nxt = 1'b0;

        if (word_done) begin
            if (!valid || ready) begin
                d_out_nxt = word;
                valid_nxt = 1'b1;
            end else begin
                overrun_nxt = 1'b1;
            end
        end else if (valid && ready) begin
            valid_nxt = 1'b0;
        end

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

`default_nettype wire
